// File: rtl/prefetch_queue.sv
// Pipelined instruction prefetch: keeps several Wishbone reads in flight and buffers the words in a 2^LGDEPTH queue.
// Define PREFETCH_QUEUE_ABORT_EN to abort in-flight reads on a flush instead of draining them.
module prefetch_queue #(
   parameter int ADDRESS_WIDTH = 32,
   parameter int DATA_WIDTH    = 32,
   parameter int LGDEPTH       = 2
) (
   input  logic                     i_clk,
   input  logic                     i_rst,
   input  logic                     i_new_pc,
   input  logic                     i_clear_cache,
   input  logic                     i_stalled_n,
   input  logic [ADDRESS_WIDTH-1:0] i_pc,
   output logic [DATA_WIDTH-1:0]    o_i,
   output logic [ADDRESS_WIDTH-1:0] o_pc,
   output logic                     o_valid,
   output logic                     o_illegal,
   output logic                     o_wb_cyc,
   output logic                     o_wb_stb,
   output logic                     o_wb_we,
   output logic [ADDRESS_WIDTH-1:0] o_wb_addr,
   output logic [DATA_WIDTH-1:0]    o_wb_data,
   input  logic                     i_wb_ack,
   input  logic                     i_wb_stall,
   input  logic                     i_wb_err,
   input  logic [DATA_WIDTH-1:0]    i_wb_data
);

   localparam int AW    = ADDRESS_WIDTH;
   localparam int DW    = DATA_WIDTH;
   localparam int DEPTH = 1 << LGDEPTH;
   localparam int CW    = LGDEPTH + 1;
   localparam int SW    = LGDEPTH + 2;

`ifdef PREFETCH_QUEUE_ABORT_EN
   localparam bit ABORT_EN = 1'b1;
`else
   localparam bit ABORT_EN = 1'b0;
`endif

   logic [DW-1:0]      q_data [DEPTH];
   logic [DEPTH-1:0]   q_ill;
   logic [LGDEPTH-1:0] rd_ptr, wr_ptr, rd_n, wr_n;
   logic [CW-1:0]      count, outstanding, count_n, outs_n;
   logic [SW-1:0]      sum_n;
   logic [AW-1:0]      head_pc, wb_addr, head_n, addr_n;
   logic               halted, draining, cyc, stb;
   logic               halted_n, draining_n, cyc_n, stb_n;
   logic               flush, accept, resp_ok, err_hit, ack_hit, pop, push, kill;

   always_comb begin
      flush   = i_new_pc || i_clear_cache;
      accept  = stb && !i_wb_stall;
      resp_ok = cyc && (outstanding != '0);
      err_hit = resp_ok && i_wb_err && !halted;
      ack_hit = resp_ok && i_wb_ack && !err_hit;
      pop     = (count != '0) && i_stalled_n;
      // Responses that belong to a flushed fetch stream are consumed but never queued.
      push    = (ack_hit || err_hit) && !draining && !flush;
      kill    = err_hit;

      count_n    = count + CW'(push) - CW'(pop);
      rd_n       = rd_ptr + LGDEPTH'(pop);
      wr_n       = wr_ptr + LGDEPTH'(push);
      outs_n     = err_hit ? '0 : (outstanding + CW'(accept) - CW'(ack_hit));
      head_n     = head_pc + AW'(pop);
      addr_n     = wb_addr + AW'(accept);
      halted_n   = halted || (err_hit && !draining);
      draining_n = draining && (outs_n != '0);

      if (flush) begin
         count_n  = '0;
         rd_n     = '0;
         wr_n     = '0;
         halted_n = 1'b0;
         if (i_new_pc) begin
            head_n = i_pc;
            addr_n = i_pc;
         end else begin
            head_n = head_pc;
            addr_n = head_pc;
         end
         if (ABORT_EN) begin
            if ((outstanding != '0) || accept)
               kill = 1'b1;
            outs_n     = '0;
            draining_n = 1'b0;
         end else begin
            draining_n = (outs_n != '0);
         end
      end

      // Credit: queued words plus reads in flight may never exceed the queue depth.
      sum_n = SW'(count_n) + SW'(outs_n);
      stb_n = !halted_n && !draining_n && !kill && (sum_n < SW'(DEPTH));
      cyc_n = stb_n || (outs_n != '0);
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         rd_ptr      <= '0;
         wr_ptr      <= '0;
         count       <= '0;
         outstanding <= '0;
         head_pc     <= '0;
         wb_addr     <= '0;
         halted      <= 1'b0;
         draining    <= 1'b0;
         cyc         <= 1'b0;
         stb         <= 1'b0;
      end else begin
         rd_ptr      <= rd_n;
         wr_ptr      <= wr_n;
         count       <= count_n;
         outstanding <= outs_n;
         head_pc     <= head_n;
         wb_addr     <= addr_n;
         halted      <= halted_n;
         draining    <= draining_n;
         cyc         <= cyc_n;
         stb         <= stb_n;
      end
   end

   always_ff @(posedge i_clk) begin
      if (push) begin
         q_data[wr_ptr] <= err_hit ? '0 : i_wb_data;
         q_ill[wr_ptr]  <= err_hit;
      end
   end

   // Head outputs are masked while empty so the unreset storage never leaks out.
   assign o_valid   = (count != '0);
   assign o_i       = o_valid ? q_data[rd_ptr] : '0;
   assign o_illegal = o_valid && q_ill[rd_ptr];
   assign o_pc      = head_pc;
   assign o_wb_cyc  = cyc;
   assign o_wb_stb  = stb;
   assign o_wb_we   = 1'b0;
   assign o_wb_addr = wb_addr;
   assign o_wb_data = '0;

endmodule
